// File: rtl/i281_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// i281_ctrl_fsm -- multi-cycle control unit for the i281 processor.
//
// Three-state controller (FETCH -> EXEC [-> MEM] -> FETCH) that latches the
// instruction word, decodes it and drives the datapath strobes.
//
// Optional feature macro: I281_CTRL_MEM_TIMEOUT_EN
//   When defined, a 4-bit counter aborts a MEM access after 16 consecutive
//   unacknowledged cycles and raises the sticky o_mem_err flag.
//   When undefined, MEM waits indefinitely and o_mem_err is tied to 0.
//
// Ports:
//   i_clk, i_reset      rising-edge clock, synchronous active-high reset
//   i_en                advance enable (0 freezes state/IR/flags, no strobes)
//   i_instr             instruction word {opcode, RX, RY, IMM}
//   i_alu_flags         ALU result flags {C,Z,V,N}
//   i_dmem_ack          data-memory completion
//   o_ir_we             IR load strobe
//   o_pc_we, o_pc_sel   PC load strobe; 0 = PC+1, 1 = PC+1+IMM
//   o_rf_ra/rb/wa       register-file read A, read B, write address
//   o_rf_we, o_flag_we  register write strobe, flag latch strobe
//   o_alu_b_imm         ALU B operand taken from IMM
//   o_alu_op            00 add, 01 sub, 10 shl, 11 shr
//   o_wb_sel            00 ALU, 01 dmem, 10 IMM, 11 input port
//   o_dmem_req/we       data-memory request / write
//   o_dmem_addr_sel     0 = IMM, 1 = IMM+RY
//   o_flags             latched flag register
//   o_mem_err           sticky memory-timeout error
// ---------------------------------------------------------------------------
module i281_ctrl_fsm #(
    parameter int unsigned REG_ADDR_W = 2,
    parameter int unsigned IMM_W      = 8
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_en,
    input  logic [4+2*REG_ADDR_W+IMM_W-1:0]     i_instr,
    input  logic [3:0]                          i_alu_flags,
    input  logic                                i_dmem_ack,
    output logic                                o_ir_we,
    output logic                                o_pc_we,
    output logic                                o_pc_sel,
    output logic [REG_ADDR_W-1:0]               o_rf_ra,
    output logic [REG_ADDR_W-1:0]               o_rf_rb,
    output logic [REG_ADDR_W-1:0]               o_rf_wa,
    output logic                                o_rf_we,
    output logic                                o_flag_we,
    output logic                                o_alu_b_imm,
    output logic [1:0]                          o_alu_op,
    output logic [1:0]                          o_wb_sel,
    output logic                                o_dmem_req,
    output logic                                o_dmem_we,
    output logic                                o_dmem_addr_sel,
    output logic [3:0]                          o_flags,
    output logic                                o_mem_err
);

    localparam int unsigned IW = 4 + 2*REG_ADDR_W + IMM_W;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0, OP_INPUT = 4'h1, OP_MOVE   = 4'h2, OP_LOADI  = 4'h3,
        OP_ADD   = 4'h4, OP_ADDI  = 4'h5, OP_SUB    = 4'h6, OP_SUBI   = 4'h7,
        OP_LOAD  = 4'h8, OP_LOADF = 4'h9, OP_STORE  = 4'hA, OP_STOREF = 4'hB,
        OP_SHIFT = 4'hC, OP_CMP   = 4'hD, OP_JUMP   = 4'hE, OP_BRANCH = 4'hF
    } op_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [IW-1:0]          r_ir;
    logic [3:0]             r_flags;

    op_e                    w_op;
    logic [REG_ADDR_W-1:0]  w_rx;
    logic [REG_ADDR_W-1:0]  w_ry;
    logic                   w_shr;
    logic                   w_unused_imm;
    logic [2:0]             w_cond;
    logic                   w_taken;
    logic                   w_is_store;
    logic                   w_is_fvar;
    logic                   w_timeout;
    logic                   w_mem_err;

    // Un-gated datapath controls; reset/enable masking is applied at the ports.
    logic                   w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_flag_we;
    logic                   w_alu_b_imm, w_dmem_req, w_dmem_we, w_dmem_addr_sel;
    logic [REG_ADDR_W-1:0]  w_rf_ra, w_rf_rb, w_rf_wa;
    logic [1:0]             w_alu_op, w_wb_sel;

    // ---------------- instruction field decode ----------------
    assign w_op         = op_e'(r_ir[IW-1 -: 4]);
    assign w_rx         = r_ir[IW-5 -: REG_ADDR_W];
    assign w_ry         = r_ir[IW-5-REG_ADDR_W -: REG_ADDR_W];
    assign w_shr        = r_ir[0];
    assign w_unused_imm = ^r_ir[IMM_W-1:1];

    // Low 3 bits of {RX,RY}; RY is at least 2 bits wide, so RX contributes bit 0.
    assign w_cond     = {w_rx[0], w_ry[1:0]};
    // Stores are A/B (opcode bit 1 set), F variants are the odd memory opcodes.
    assign w_is_store = r_ir[IW-3];
    assign w_is_fvar  = r_ir[IW-4];

    // Branch condition evaluated on latched flags: bit2 = Z, bit1 = V, bit0 = N.
    always_comb begin
        w_taken = 1'b0;
        case (w_cond)
            3'b000:  w_taken = r_flags[2];
            3'b001:  w_taken = ~r_flags[2];
            3'b010:  w_taken = ~r_flags[2] & (r_flags[0] ~^ r_flags[1]);
            3'b011:  w_taken = r_flags[0] ~^ r_flags[1];
            default: w_taken = 1'b0;
        endcase
    end

    // ---------------- optional memory timeout ----------------
`ifdef I281_CTRL_MEM_TIMEOUT_EN
    logic [3:0] r_to_cnt;
    logic       r_mem_err;

    // Counter holds the number of unacked MEM cycles already elapsed, so the
    // 16th unacked cycle is the one seen with the counter at 15.
    assign w_timeout = (r_state == S_MEM) && !i_dmem_ack && (r_to_cnt == 4'hF);
    assign w_mem_err = r_mem_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_to_cnt  <= '0;
            r_mem_err <= 1'b0;
        end else if (i_en) begin
            if ((r_state == S_MEM) && !i_dmem_ack && !w_timeout)
                r_to_cnt <= r_to_cnt + 4'd1;
            else
                r_to_cnt <= '0;
            if (w_timeout)
                r_mem_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_mem_err = 1'b0;
`endif

    // ---------------- state, IR and flag registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_flags <= '0;
        end else if (i_en) begin
            r_state <= w_state_nxt;
            if (w_ir_we)
                r_ir <= i_instr;
            if (w_flag_we)
                r_flags <= i_alu_flags;
        end
    end

    // ---------------- next state and control decode ----------------
    always_comb begin
        w_state_nxt     = r_state;
        w_ir_we         = 1'b0;
        w_pc_we         = 1'b0;
        w_pc_sel        = 1'b0;
        w_rf_ra         = '0;
        w_rf_rb         = '0;
        w_rf_wa         = '0;
        w_rf_we         = 1'b0;
        w_flag_we       = 1'b0;
        w_alu_b_imm     = 1'b0;
        w_alu_op        = 2'b00;
        w_wb_sel        = 2'b00;
        w_dmem_req      = 1'b0;
        w_dmem_we       = 1'b0;
        w_dmem_addr_sel = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                w_ir_we     = 1'b1;
                w_state_nxt = S_EXEC;
            end

            S_EXEC: begin
                w_state_nxt = S_FETCH;
                case (w_op)
                    OP_NOOP: begin
                        w_pc_we = 1'b1;
                    end
                    OP_INPUT, OP_MOVE, OP_LOADI: begin
                        w_rf_we  = 1'b1;
                        w_rf_wa  = w_rx;
                        w_rf_rb  = w_ry;
                        w_pc_we  = 1'b1;
                        w_wb_sel = (w_op == OP_INPUT) ? 2'b11 :
                                   (w_op == OP_LOADI) ? 2'b10 : 2'b00;
                    end
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_SHIFT, OP_CMP: begin
                        w_rf_ra     = w_rx;
                        w_rf_rb     = w_ry;
                        w_rf_wa     = w_rx;
                        w_rf_we     = (w_op != OP_CMP);
                        w_flag_we   = 1'b1;
                        w_pc_we     = 1'b1;
                        w_alu_b_imm = (w_op == OP_ADDI) || (w_op == OP_SUBI);
                        if (w_op == OP_SHIFT)
                            w_alu_op = {1'b1, w_shr};
                        else if ((w_op == OP_ADD) || (w_op == OP_ADDI))
                            w_alu_op = 2'b00;
                        else
                            w_alu_op = 2'b01;
                    end
                    OP_LOAD, OP_LOADF, OP_STORE, OP_STOREF: begin
                        w_rf_ra         = w_ry;
                        w_rf_rb         = w_rx;
                        w_dmem_addr_sel = w_is_fvar;
                        w_state_nxt     = S_MEM;
                    end
                    OP_JUMP: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = 1'b1;
                    end
                    OP_BRANCH: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = w_taken;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                w_rf_ra         = w_ry;
                w_rf_rb         = w_rx;
                w_dmem_addr_sel = w_is_fvar;
                w_dmem_req      = 1'b1;
                w_dmem_we       = w_is_store;
                if (i_dmem_ack || w_timeout) begin
                    w_pc_we     = 1'b1;
                    w_state_nxt = S_FETCH;
                    if (i_dmem_ack && !w_is_store) begin
                        w_rf_we  = 1'b1;
                        w_rf_wa  = w_rx;
                        w_wb_sel = 2'b01;
                    end
                end
            end

            default: w_state_nxt = S_FETCH;
        endcase
    end

    // ---------------- port masking ----------------
    // Strobes are suppressed both in reset and while frozen; everything else
    // is only forced low by reset.
    logic w_strobe_ok;
    assign w_strobe_ok = i_en & ~i_reset;

    assign o_ir_we         = w_ir_we    & w_strobe_ok;
    assign o_pc_we         = w_pc_we    & w_strobe_ok;
    assign o_rf_we         = w_rf_we    & w_strobe_ok;
    assign o_flag_we       = w_flag_we  & w_strobe_ok;
    assign o_dmem_req      = w_dmem_req & w_strobe_ok;
    assign o_dmem_we       = w_dmem_we  & w_strobe_ok;

    assign o_pc_sel        = w_pc_sel        & ~i_reset;
    assign o_alu_b_imm     = w_alu_b_imm     & ~i_reset;
    assign o_dmem_addr_sel = w_dmem_addr_sel & ~i_reset;
    assign o_mem_err       = w_mem_err       & ~i_reset;
    assign o_rf_ra         = i_reset ? '0 : w_rf_ra;
    assign o_rf_rb         = i_reset ? '0 : w_rf_rb;
    assign o_rf_wa         = i_reset ? '0 : w_rf_wa;
    assign o_alu_op        = i_reset ? '0 : w_alu_op;
    assign o_wb_sel        = i_reset ? '0 : w_wb_sel;
    assign o_flags         = i_reset ? '0 : r_flags;

endmodule
